// File: rtl/branch_update_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : branch_update_if
//  Brief    : Resolution bus from the branch unit to the predictor updater.
//             The master (branch unit) presents a resolved branch together
//             with what fetch predicted for it; the slave raises ready when
//             it can take a resolution.
//  Revision : 1.0  initial release
// ============================================================================
interface branch_update_if;
    logic        res_valid_i;
    logic        res_ready_o;
    logic [31:0] res_pc_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        res_pred_taken_i;
    logic        res_pred_hit_i;
    logic [31:0] res_pred_target_i;

    modport master (
        output res_valid_i,
        output res_pc_i,
        output res_taken_i,
        output res_target_i,
        output res_pred_taken_i,
        output res_pred_hit_i,
        output res_pred_target_i,
        input  res_ready_o
    );

    modport slave (
        input  res_valid_i,
        input  res_pc_i,
        input  res_taken_i,
        input  res_target_i,
        input  res_pred_taken_i,
        input  res_pred_hit_i,
        input  res_pred_target_i,
        output res_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_update.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : branch_update
//  Brief    : Branch-resolution updater. After reset it sweeps the local
//             predictor and BTB clearing every entry, then for each accepted
//             resolution updates a 2-bit saturating counter, writes the BTB on
//             taken branches, and raises a one-cycle redirect on mispredicts.
//             Every output is registered (one cycle after acceptance).
//  Revision : 1.0  initial release
// ============================================================================
module branch_update #(
    parameter int local_entries = 128,
    parameter int btb_entries   = 128
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    branch_update_if.slave                     res,
    output logic                               redirect_o,
    output logic [31:0]                        redirect_pc_o,
    output logic                               pht_we_o,
    output logic [$clog2(local_entries)-1:0]   pht_idx_o,
    output logic                               pht_taken_o,
    output logic                               btb_we_o,
    output logic [$clog2(btb_entries)-1:0]     btb_idx_o,
    output logic [29-$clog2(btb_entries):0]    btb_tag_o,
    output logic [29:0]                        btb_target_o,
    output logic                               btb_valid_o,
    output logic [31:0]                        mispredict_cnt_o
);

    localparam int c_LW = $clog2(local_entries);
    localparam int c_BW = $clog2(btb_entries);
    localparam int c_N  = (local_entries > btb_entries) ? local_entries : btb_entries;
    localparam int c_NW = $clog2(c_N);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Registered state and outputs
    state_t            r_state;
    logic [c_NW-1:0]   r_idx;
    logic              r_done;       // last sweep index already written
    logic              r_ready;
    logic              r_redirect;
    logic [31:0]       r_redirect_pc;
    logic              r_pht_we;
    logic [c_LW-1:0]   r_pht_idx;
    logic              r_pht_taken;
    logic              r_btb_we;
    logic [c_BW-1:0]   r_btb_idx;
    logic [29-c_BW:0]  r_btb_tag;
    logic [29:0]       r_btb_target;
    logic              r_btb_valid;
    logic [31:0]       r_mis_cnt;
    logic [1:0]        r_cnt [local_entries];

    // Next-state values
    state_t            w_state_nxt;
    logic [c_NW-1:0]   w_idx_nxt;
    logic              w_done_nxt;
    logic              w_ready_nxt;
    logic              w_redirect_nxt;
    logic [31:0]       w_redirect_pc_nxt;
    logic              w_pht_we_nxt;
    logic [c_LW-1:0]   w_pht_idx_nxt;
    logic              w_pht_taken_nxt;
    logic              w_btb_we_nxt;
    logic [c_BW-1:0]   w_btb_idx_nxt;
    logic [29-c_BW:0]  w_btb_tag_nxt;
    logic [29:0]       w_btb_target_nxt;
    logic              w_btb_valid_nxt;
    logic [31:0]       w_mis_cnt_nxt;
    logic              w_cnt_we;
    logic [c_LW-1:0]   w_cnt_widx;
    logic [1:0]        w_cnt_wdata;

    // Decode of the presented resolution
    logic              w_accept;
    logic [c_LW-1:0]   w_lidx;
    logic [c_BW-1:0]   w_bidx;
    logic [29-c_BW:0]  w_tag;
    logic [1:0]        w_cur;
    logic [1:0]        w_new;
    logic              w_mis;
    logic [31:0]       w_rpc;
    logic              w_unused;

    assign w_accept = res.res_valid_i & r_ready;
    assign w_lidx   = res.res_pc_i[c_LW+1:2];
    assign w_bidx   = res.res_pc_i[c_BW+1:2];
    assign w_tag    = res.res_pc_i[31:c_BW+2];
    assign w_cur    = r_cnt[w_lidx];
    assign w_new    = res.res_taken_i ? ((w_cur == 2'b11) ? 2'b11 : w_cur + 2'b01)
                                      : ((w_cur == 2'b00) ? 2'b00 : w_cur - 2'b01);
    assign w_mis    = (res.res_taken_i != res.res_pred_taken_i) |
                      (res.res_taken_i & res.res_pred_taken_i &
                       (~res.res_pred_hit_i |
                        (res.res_pred_target_i[31:2] != res.res_target_i[31:2])));
    // Not-taken restart wraps naturally past the top of the address space
    assign w_rpc    = res.res_taken_i ? {res.res_target_i[31:2], 2'b00}
                                      : ({res.res_pc_i[31:2], 2'b00} + 32'd4);
    // Byte-offset bits carry no information for word-aligned branches
    assign w_unused = ^{res.res_pc_i[1:0], res.res_target_i[1:0], res.res_pred_target_i[1:0]};

    assign res.res_ready_o  = r_ready;
    assign redirect_o       = r_redirect;
    assign redirect_pc_o    = r_redirect_pc;
    assign pht_we_o         = r_pht_we;
    assign pht_idx_o        = r_pht_idx;
    assign pht_taken_o      = r_pht_taken;
    assign btb_we_o         = r_btb_we;
    assign btb_idx_o        = r_btb_idx;
    assign btb_tag_o        = r_btb_tag;
    assign btb_target_o     = r_btb_target;
    assign btb_valid_o      = r_btb_valid;
    assign mispredict_cnt_o = r_mis_cnt;

    // Next-state and next-output computation for the sweep/update FSM
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_done_nxt        = r_done;
        w_ready_nxt       = r_ready;
        w_redirect_nxt    = 1'b0;
        w_redirect_pc_nxt = r_redirect_pc;
        w_pht_we_nxt      = 1'b0;
        w_pht_idx_nxt     = r_pht_idx;
        w_pht_taken_nxt   = r_pht_taken;
        w_btb_we_nxt      = 1'b0;
        w_btb_idx_nxt     = r_btb_idx;
        w_btb_tag_nxt     = r_btb_tag;
        w_btb_target_nxt  = r_btb_target;
        w_btb_valid_nxt   = r_btb_valid;
        w_mis_cnt_nxt     = r_mis_cnt;
        w_cnt_we          = 1'b0;
        w_cnt_widx        = w_lidx;
        w_cnt_wdata       = w_new;

        case (r_state)
            S_INIT: begin
                if (r_done) begin
                    w_state_nxt = S_RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_pht_we_nxt     = 1'b1;
                    w_pht_idx_nxt    = r_idx[c_LW-1:0];
                    w_pht_taken_nxt  = 1'b0;
                    w_btb_we_nxt     = 1'b1;
                    w_btb_idx_nxt    = r_idx[c_BW-1:0];
                    w_btb_tag_nxt    = '0;
                    w_btb_target_nxt = '0;
                    w_btb_valid_nxt  = 1'b0;
                    w_cnt_we         = 1'b1;
                    w_cnt_widx       = r_idx[c_LW-1:0];
                    w_cnt_wdata      = 2'b01;
                    if (r_idx == c_NW'(c_N - 1)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + c_NW'(1);
                    end
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    w_cnt_we          = 1'b1;
                    w_pht_we_nxt      = 1'b1;
                    w_pht_idx_nxt     = w_lidx;
                    w_pht_taken_nxt   = w_new[1];
                    w_btb_we_nxt      = res.res_taken_i;
                    w_btb_idx_nxt     = w_bidx;
                    w_btb_tag_nxt     = w_tag;
                    w_btb_target_nxt  = res.res_target_i[31:2];
                    w_btb_valid_nxt   = 1'b1;
                    w_redirect_nxt    = w_mis;
                    w_redirect_pc_nxt = w_rpc;
                    if (w_mis) begin
                        w_mis_cnt_nxt = r_mis_cnt + 32'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // State and output registers; reset restarts the sweep from index 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_INIT;
            r_idx         <= '0;
            r_done        <= 1'b0;
            r_ready       <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_pht_we      <= 1'b0;
            r_pht_idx     <= '0;
            r_pht_taken   <= 1'b0;
            r_btb_we      <= 1'b0;
            r_btb_idx     <= '0;
            r_btb_tag     <= '0;
            r_btb_target  <= '0;
            r_btb_valid   <= 1'b0;
            r_mis_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_done        <= w_done_nxt;
            r_ready       <= w_ready_nxt;
            r_redirect    <= w_redirect_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
            r_pht_we      <= w_pht_we_nxt;
            r_pht_idx     <= w_pht_idx_nxt;
            r_pht_taken   <= w_pht_taken_nxt;
            r_btb_we      <= w_btb_we_nxt;
            r_btb_idx     <= w_btb_idx_nxt;
            r_btb_tag     <= w_btb_tag_nxt;
            r_btb_target  <= w_btb_target_nxt;
            r_btb_valid   <= w_btb_valid_nxt;
            r_mis_cnt     <= w_mis_cnt_nxt;
        end
    end

    // Counter array write, same edge as the output update so the next
    // resolution to the same entry reads the new value
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_cnt_we) begin
            r_cnt[w_cnt_widx] <= w_cnt_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_update.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_branch_update
//  Brief    : Directed self-checking bench for branch_update (128/128).
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_update;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        pht_we_o;
    logic [6:0]  pht_idx_o;
    logic        pht_taken_o;
    logic        btb_we_o;
    logic [6:0]  btb_idx_o;
    logic [22:0] btb_tag_o;
    logic [29:0] btb_target_o;
    logic        btb_valid_o;
    logic [31:0] mispredict_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    branch_update_if u_if ();

    branch_update #(.local_entries(128), .btb_entries(128)) u_dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .res              (u_if.slave),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .pht_we_o         (pht_we_o),
        .pht_idx_o        (pht_idx_o),
        .pht_taken_o      (pht_taken_o),
        .btb_we_o         (btb_we_o),
        .btb_idx_o        (btb_idx_o),
        .btb_tag_o        (btb_tag_o),
        .btb_target_o     (btb_target_o),
        .btb_valid_o      (btb_valid_o),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic        phit;
        logic [31:0] ptgt;
        logic [6:0]  e_pidx;
        logic        e_ptaken;
        logic        e_bwe;
        logic [6:0]  e_bidx;
        logic [22:0] e_btag;
        logic [29:0] e_btgt;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic phit, input logic [31:0] ptgt);
        u_if.res_valid_i       = v;
        u_if.res_pc_i          = pc;
        u_if.res_taken_i       = tk;
        u_if.res_target_i      = tgt;
        u_if.res_pred_taken_i  = ptk;
        u_if.res_pred_hit_i    = phit;
        u_if.res_pred_target_i = ptgt;
    endtask

    // Called at a negedge just after rst_i is released; follows the sweep
    task automatic sweep(input string nm);
        int len;
        int errs;
        len  = 0;
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_i);
            if (u_if.res_ready_o === 1'b1) break;
            if (pht_we_o !== 1'b1 || pht_idx_o !== 7'(len) || pht_taken_o !== 1'b0 ||
                btb_we_o !== 1'b1 || btb_idx_o !== 7'(len) || btb_valid_o !== 1'b0 ||
                btb_tag_o !== 23'd0 || btb_target_o !== 30'd0 || redirect_o !== 1'b0)
                errs++;
            len++;
        end
        chk({nm, "_init_len"}, 32'(len), 32'd128);
        chk({nm, "_sweep_seq_errs"}, 32'(errs), 32'd0);
        chk({nm, "_run_pht_we"}, {31'd0, pht_we_o}, 32'd0);
        chk({nm, "_run_btb_we"}, {31'd0, btb_we_o}, 32'd0);
    endtask

    initial begin
        // pc, tk, tgt, ptk, phit, ptgt | pidx, ptaken, bwe, bidx, btag, btgt, redir, rpc, cnt
        tbl[0]  = '{32'h200, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0,    7'd0,   1'b1, 1'b1, 7'd0,   23'd1, 30'h100, 1'b1, 32'h400, 32'd1};
        tbl[1]  = '{32'h100, 1'b1, 32'h180, 1'b1, 1'b1, 32'h180,  7'd64,  1'b1, 1'b1, 7'd64,  23'd0, 30'h060, 1'b0, 32'h0,   32'd1};
        tbl[2]  = '{32'h100, 1'b1, 32'h180, 1'b1, 1'b1, 32'h180,  7'd64,  1'b1, 1'b1, 7'd64,  23'd0, 30'h060, 1'b0, 32'h0,   32'd1};
        tbl[3]  = '{32'h100, 1'b1, 32'h180, 1'b1, 1'b1, 32'h180,  7'd64,  1'b1, 1'b1, 7'd64,  23'd0, 30'h060, 1'b0, 32'h0,   32'd1};
        tbl[4]  = '{32'h100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h180,  7'd64,  1'b1, 1'b0, 7'd0,   23'd0, 30'h0,   1'b1, 32'h104, 32'd2};
        tbl[5]  = '{32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    7'd64,  1'b0, 1'b0, 7'd0,   23'd0, 30'h0,   1'b0, 32'h0,   32'd2};
        tbl[6]  = '{32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1000, 7'd127, 1'b0, 1'b0, 7'd0, 23'd0, 30'h0,  1'b1, 32'h0,   32'd3};
        tbl[7]  = '{32'h300, 1'b1, 32'h500, 1'b1, 1'b0, 32'h500,  7'd64,  1'b1, 1'b1, 7'd64,  23'd1, 30'h140, 1'b1, 32'h500, 32'd4};
        tbl[8]  = '{32'h300, 1'b1, 32'h500, 1'b1, 1'b1, 32'h504,  7'd64,  1'b1, 1'b1, 7'd64,  23'd1, 30'h140, 1'b1, 32'h500, 32'd5};
        tbl[9]  = '{32'h300, 1'b1, 32'h503, 1'b1, 1'b1, 32'h500,  7'd64,  1'b1, 1'b1, 7'd64,  23'd1, 30'h140, 1'b0, 32'h0,   32'd5};
        tbl[10] = '{32'h402, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    7'd0,   1'b0, 1'b0, 7'd0,   23'd0, 30'h0,   1'b0, 32'h0,   32'd5};

        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset values while reset is held
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_ready",    {31'd0, u_if.res_ready_o}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rst_rpc",      redirect_pc_o, 32'd0);
        chk("rst_pht_we",   {31'd0, pht_we_o}, 32'd0);
        chk("rst_btb_we",   {31'd0, btb_we_o}, 32'd0);
        chk("rst_cnt",      mispredict_cnt_o, 32'd0);
        rst_i = 1'b0;

        // Abort a sweep partway through, then run a full one
        repeat (50) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midinit_rst_pht_we", {31'd0, pht_we_o}, 32'd0);
        chk("midinit_rst_btb_we", {31'd0, btb_we_o}, 32'd0);
        rst_i = 1'b0;
        sweep("boot");

        // Back-to-back table of resolutions
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, tbl[i].pc, tbl[i].tk, tbl[i].tgt, tbl[i].ptk, tbl[i].phit, tbl[i].ptgt);
            @(negedge clk_i);
            chk($sformatf("v%0d_pht_we", i),    {31'd0, pht_we_o}, 32'd1);
            chk($sformatf("v%0d_pht_idx", i),   {25'd0, pht_idx_o}, {25'd0, tbl[i].e_pidx});
            chk($sformatf("v%0d_pht_taken", i), {31'd0, pht_taken_o}, {31'd0, tbl[i].e_ptaken});
            chk($sformatf("v%0d_btb_we", i),    {31'd0, btb_we_o}, {31'd0, tbl[i].e_bwe});
            if (tbl[i].e_bwe) begin
                chk($sformatf("v%0d_btb_idx", i),   {25'd0, btb_idx_o}, {25'd0, tbl[i].e_bidx});
                chk($sformatf("v%0d_btb_tag", i),   {9'd0, btb_tag_o}, {9'd0, tbl[i].e_btag});
                chk($sformatf("v%0d_btb_tgt", i),   {2'd0, btb_target_o}, {2'd0, tbl[i].e_btgt});
                chk($sformatf("v%0d_btb_valid", i), {31'd0, btb_valid_o}, 32'd1);
            end
            chk($sformatf("v%0d_redirect", i), {31'd0, redirect_o}, {31'd0, tbl[i].e_redir});
            if (tbl[i].e_redir)
                chk($sformatf("v%0d_rpc", i), redirect_pc_o, tbl[i].e_rpc);
            chk($sformatf("v%0d_cnt", i), mispredict_cnt_o, tbl[i].e_cnt);
        end

        // Idle cycle: no writes, no redirect
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        chk("idle_pht_we",   {31'd0, pht_we_o}, 32'd0);
        chk("idle_btb_we",   {31'd0, btb_we_o}, 32'd0);
        chk("idle_redirect", {31'd0, redirect_o}, 32'd0);
        chk("idle_cnt",      mispredict_cnt_o, 32'd5);

        // Redirect lasts exactly one cycle
        drive(1'b1, 32'h500, 1'b1, 32'h800, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("pulse_redirect", {31'd0, redirect_o}, 32'd1);
        chk("pulse_rpc",      redirect_pc_o, 32'h800);
        chk("pulse_cnt",      mispredict_cnt_o, 32'd6);
        @(negedge clk_i);
        chk("pulse_end_redirect", {31'd0, redirect_o}, 32'd0);
        chk("pulse_end_cnt",      mispredict_cnt_o, 32'd6);

        // Reset during an accept cycle: the resolution is dropped
        drive(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h180);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rstacc_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rstacc_pht_we",   {31'd0, pht_we_o}, 32'd0);
        chk("rstacc_btb_we",   {31'd0, btb_we_o}, 32'd0);
        chk("rstacc_cnt",      mispredict_cnt_o, 32'd0);
        chk("rstacc_ready",    {31'd0, u_if.res_ready_o}, 32'd0);
        rst_i = 1'b0;
        // valid stays high across the sweep; it is only taken once ready
        sweep("rerun");
        @(negedge clk_i);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("post_pht_idx",   {25'd0, pht_idx_o}, 32'd64);
        chk("post_pht_taken", {31'd0, pht_taken_o}, 32'd0);
        chk("post_redirect",  {31'd0, redirect_o}, 32'd1);
        chk("post_rpc",       redirect_pc_o, 32'h104);
        chk("post_cnt",       mispredict_cnt_o, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_update.md
BRANCH_UPDATE -- requirements
Module: branch_update

Interface
REQ-001 The block SHALL take parameter local_entries, default 128, as the number of local-predictor entries (power of two, >=4).
REQ-002 The block SHALL take parameter btb_entries, default 128, as the number of BTB sets (power of two, >=4).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports named as below.
REQ-004 clk_i  in  1  clock; all state on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 res_valid_i  in  1  resolved branch presented by branch unit this cycle.
REQ-007 res_ready_o  out  1  block accepts resolutions; res_valid_i ignored while low.
REQ-008 res_pc_i  in  32  PC of resolved branch (bits [1:0] ignored).
REQ-009 res_taken_i  in  1  actual direction.
REQ-010 res_target_i  in  32  actual taken target (bits [1:0] ignored).
REQ-011 res_pred_taken_i / res_pred_hit_i  in  1 each  direction and BTB-hit predicted at fetch.
REQ-012 res_pred_target_i  in  32  target predicted at fetch.
REQ-013 redirect_o  out  1  one-cycle pulse: flush and restart fetch.
REQ-014 redirect_pc_o  out  32  restart address, valid when redirect_o high.
REQ-015 pht_we_o, pht_idx_o[LW-1:0], pht_taken_o  out  local-predictor write port; LW=clog2(local_entries).
REQ-016 btb_we_o, btb_idx_o[BW-1:0], btb_tag_o[30-BW-1:0], btb_target_o[29:0], btb_valid_o  out  BTB write port; BW=clog2(btb_entries).
REQ-017 mispredict_cnt_o  out  32  count of redirects since reset.

Function
REQ-018 FSM states: INIT, RUN; INIT sweeps index i = 0..N-1, N = max(local_entries, btb_entries), one index per cycle.
REQ-019 In INIT, each cycle SHALL assert pht_we_o (idx i mod local_entries, taken 0) and btb_we_o (idx i mod btb_entries, valid 0, tag/target 0); res_ready_o=0.
REQ-020 INIT SHALL move to RUN the cycle after i=N-1 is written; res_ready_o=1 in RUN only.
REQ-021 Internal 2-bit saturating counter per local entry; INIT SHALL set each to 01.
REQ-022 Index: local = res_pc_i[LW+1:2]; BTB set = res_pc_i[BW+1:2]; tag = res_pc_i[31:BW+2].
REQ-023 Accepted resolution (res_valid_i & res_ready_o) at edge N SHALL produce all outputs in cycle N+1 (latency 1, registered); no output is driven combinationally from inputs.
REQ-024 Counter update: taken -> min(c+1,3); not taken -> max(c-1,0); pht_we_o=1, pht_taken_o = new c[1]; the array is written at the same edge, so back-to-back same-index resolutions see the updated value.
REQ-025 BTB: taken -> btb_we_o=1, valid 1, tag per REQ-022, btb_target_o = res_target_i[31:2]; not taken -> btb_we_o=0.
REQ-026 Mispredict = (taken != pred_taken) | (taken & pred_taken & (!pred_hit | pred_target[31:2] != target[31:2])).
REQ-027 On mispredict, redirect_o=1 for exactly one cycle; redirect_pc_o = taken ? {target[31:2],2'b00} : {pc[31:2],2'b00}+4 (wraps mod 2^32).
REQ-028 mispredict_cnt_o SHALL increment by 1 per redirect, wrapping from 0xFFFFFFFF to 0.
REQ-029 All write enables and redirect_o SHALL be 0 in any RUN cycle not following an accepted resolution.

Reset
REQ-030 While rst_i is sampled high: state=INIT, i=0, redirect_o=0, redirect_pc_o=0, pht_we_o=0, btb_we_o=0, res_ready_o=0, mispredict_cnt_o=0.
REQ-031 Reset asserted mid-INIT or mid-RUN SHALL abort the current sweep/update and restart INIT from i=0 the cycle after rst_i falls.

Verification
REQ-032 Reset then idle -> res_ready_o low exactly 128 cycles; pht/btb writes to idx 0..127 in order; then ready=1.
REQ-033 PC 0x100 taken x3 from counter 01 -> pht_taken_o 1,1,1; internal counter 10,11,11 (saturates).
REQ-034 PC 0x200, pred not-taken, actual taken to 0x400 -> next cycle redirect_o=1, redirect_pc_o=0x400, btb write set 0x00, target 0x100, cnt=1.
REQ-035 PC 0xFFFFFFFC, pred taken, actual not taken -> redirect_pc_o=0x00000000.
REQ-036 Taken, pred_taken=1, pred_hit=1, pred_target==target -> no redirect, count unchanged; same with pred_hit=0 -> redirect.
REQ-037 rst_i asserted during a resolution's accept cycle -> no writes/redirect following; INIT restarts at idx 0.
